approx_mul_acc: RTL and testbench

Streaming accumulator that directly consumes the 24-bit products of the unsigned 12x12 approximate multipliers in the library. It sums a frame of products and emits one result per frame on a valid/ready output. Frame length is fixed by parameter or cut short by a last flag. It is the standard downstream stage for dot-product and FIR-style evaluation of approximate multipliers on FPGA.

---
 rtl/approx_mul_acc.sv | 122 ++++++++++++
 tb/tb_approx_mul_acc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_acc.sv
// approx_mul_acc: streaming accumulator for 24-bit approximate-multiplier products.
// Sums up to LEN beats per frame, or fewer when in_last closes the frame early, and
// presents one {out_sum, out_count, out_ovf} result per frame on a valid/ready port.
// Optional feature macro: APPROX_ACC_SAT_EN.
//   defined   -> additions saturate at 2^ACC_W-1 and out_ovf flags any frame that overflowed
//   undefined -> acc wraps modulo 2^ACC_W and out_ovf is tied to 0
module approx_mul_acc #(
  parameter int ACC_W = 32,
  parameter int LEN   = 16,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;
  logic             final_beat;

  // Both handshake outputs decode the state register only, so neither has a
  // combinational path from in_valid or out_ready.
  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);

  assign beat       = in_valid && in_ready;
  assign cnt_inc    = cnt + 1'b1;
  assign final_beat = in_last || (cnt_inc == LEN_C);

`ifdef APPROX_ACC_SAT_EN
  logic             ovf;
  logic             ovf_next;
  logic [ACC_W:0]   sum_ext;

  // Add with one extra bit; the carry-out clamps acc to all-ones and sets the sticky flag.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a value on every
    // path (defaults first); a missed path would infer a latch.
    sum_ext  = {1'b0, acc} + (ACC_W + 1)'(in_prod);
    acc_next = sum_ext[ACC_W-1:0];
    ovf_next = ovf;
    if (sum_ext[ACC_W]) begin
      acc_next = '1;
      ovf_next = 1'b1;
    end
  end
`else
  // Plain modulo-2^ACC_W accumulation; the carry-out is simply discarded.
  always_comb begin
    acc_next = acc + ACC_W'(in_prod);
  end

  assign out_ovf = 1'b0;
`endif

  // Frame FSM: accumulate beats in ST_ACC, present the latched result in ST_HOLD.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
`ifdef APPROX_ACC_SAT_EN
      ovf       <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_ACC: begin
          if (beat) begin
            acc <= acc_next;
            cnt <= cnt_inc;
`ifdef APPROX_ACC_SAT_EN
            ovf <= ovf_next;
`endif
            // in_last on the LEN-th beat closes just this one frame.
            if (final_beat) begin
              out_sum   <= acc_next;
              out_count <= cnt_inc;
`ifdef APPROX_ACC_SAT_EN
              out_ovf   <= ovf_next;
`endif
              state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Results stay put until consumed; in_valid is ignored here.
          if (out_ready) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
`ifdef APPROX_ACC_SAT_EN
            ovf   <= 1'b0;
`endif
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mul_acc.sv
// tb_approx_mul_acc: self-checking bench for approx_mul_acc.
// Three instances (LEN=4/ACC_W=32, LEN=16/ACC_W=24, LEN=1/ACC_W=32) share one stimulus
// bus; sel routes in_valid to one instance and muxes its outputs back for checking.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_approx_mul_acc;

`ifdef APPROX_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_prod;
  logic        in_last;
  logic        out_ready;
  int          sel;

  logic        ir0, ov0, ovf0;
  logic [31:0] sum0;
  logic [2:0]  cnt0;
  logic        ir1, ov1, ovf1;
  logic [23:0] sum1;
  logic [4:0]  cnt1;
  logic        ir2, ov2, ovf2;
  logic [31:0] sum2;
  logic [0:0]  cnt2;

  logic        ir_m, ov_m, ovf_m;
  logic [31:0] sum_m;
  logic [15:0] cnt_m;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  approx_mul_acc #(.ACC_W(32), .LEN(4)) u_len4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir0),
    .in_prod(in_prod), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
    .out_sum(sum0), .out_count(cnt0), .out_ovf(ovf0));

  approx_mul_acc #(.ACC_W(24), .LEN(16)) u_w24 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir1),
    .in_prod(in_prod), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
    .out_sum(sum1), .out_count(cnt1), .out_ovf(ovf1));

  approx_mul_acc #(.ACC_W(32), .LEN(1)) u_len1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(ir2),
    .in_prod(in_prod), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
    .out_sum(sum2), .out_count(cnt2), .out_ovf(ovf2));

  always_comb begin
    ir_m = ir0; ov_m = ov0; ovf_m = ovf0; sum_m = sum0; cnt_m = 16'(cnt0);
    case (sel)
      1: begin ir_m = ir1; ov_m = ov1; ovf_m = ovf1; sum_m = 32'(sum1); cnt_m = 16'(cnt1); end
      2: begin ir_m = ir2; ov_m = ov2; ovf_m = ovf2; sum_m = sum2; cnt_m = 16'(cnt2); end
      default: ;
    endcase
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Apply inputs for one cycle (called at a falling edge), return at the next falling edge.
  task automatic drive(input logic v, input logic [23:0] p, input logic l, input logic r);
    in_valid = v; in_prod = p; in_last = l; out_ready = r;
    @(negedge clk);
  endtask

  // ---------------- reference model (frame = list of beats) ----------------
  longint m_q[$];
  bit     m_hold;
  int     m_len, m_w;
  longint m_sum;
  int     m_cnt;
  bit     m_ovf;

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    m_q.delete();
    m_hold = 1'b0;
  endtask

  task automatic model_close();
    longint tot, mx;
    tot = 0;
    foreach (m_q[i]) tot += m_q[i];
    mx = (64'sd1 <<< m_w) - 1;
    m_cnt = m_q.size();
    if (SAT) begin
      m_sum = (tot > mx) ? mx : tot;
      m_ovf = (tot > mx);
    end else begin
      m_sum = tot & mx;
      m_ovf = 1'b0;
    end
  endtask

  task automatic model_cycle(input logic v, input logic [23:0] p, input logic l, input logic r);
    drive(v, p, l, r);
    if (!m_hold) begin
      if (v) begin
        m_q.push_back(longint'(p));
        if (l || m_q.size() == m_len) begin
          model_close();
          m_hold = 1'b1;
        end
      end
    end else if (r) begin
      m_hold = 1'b0;
      m_q.delete();
    end
    check("m_in_ready", 64'(ir_m), 64'(!m_hold));
    check("m_out_valid", 64'(ov_m), 64'(m_hold));
    if (m_hold) begin
      check("m_out_sum", 64'(sum_m), 64'(m_sum));
      check("m_out_count", 64'(cnt_m), 64'(m_cnt));
      check("m_out_ovf", 64'(ovf_m), 64'(m_ovf));
    end
  endtask

  task automatic select(input int s);
    sel = s;
    m_len = (s == 0) ? 4 : (s == 1) ? 16 : 1;
    m_w   = (s == 1) ? 24 : 32;
  endtask

  // ---------------- vector table for the LEN=4 instance ----------------
  typedef struct {
    logic        v;
    logic [23:0] p;
    logic        l;
    logic        r;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_sum;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [23:0] rp;
    // Full frame of 4 beats, no in_last; result one cycle after the 4th beat.
    tbl[0]  = '{1'b1, 24'h100000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       16'd0};
    tbl[1]  = '{1'b1, 24'h200000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       16'd0};
    tbl[2]  = '{1'b1, 24'h300000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       16'd0};
    tbl[3]  = '{1'b1, 24'hF00000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1500000, 16'd4};
    tbl[4]  = '{1'b1, 24'h000777, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1500000, 16'd4};
    tbl[5]  = '{1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       16'd0};
    // Early close with in_last, then the next frame starts from zero.
    tbl[6]  = '{1'b1, 24'd5,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       16'd0};
    tbl[7]  = '{1'b1, 24'd7,      1'b1, 1'b0, 1'b0, 1'b1, 32'd12,      16'd2};
    tbl[8]  = '{1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       16'd0};
    tbl[9]  = '{1'b1, 24'd9,      1'b1, 1'b0, 1'b0, 1'b1, 32'd9,       16'd1};
    tbl[10] = '{1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       16'd0};
    // in_last on the LEN-th beat closes a single frame.
    tbl[11] = '{1'b1, 24'd1,      1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       16'd0};
    tbl[12] = '{1'b1, 24'd1,      1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       16'd0};
    tbl[13] = '{1'b1, 24'd1,      1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       16'd0};
    tbl[14] = '{1'b1, 24'd1,      1'b1, 1'b1, 1'b0, 1'b1, 32'd4,       16'd4};
    tbl[15] = '{1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       16'd0};
    tbl[16] = '{1'b1, 24'd2,      1'b1, 1'b0, 1'b0, 1'b1, 32'd2,       16'd1};
    tbl[17] = '{1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       16'd0};

    rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    select(0);
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_out_valid", 64'(ov_m), 64'd0);
    check("rst_out_sum",   64'(sum_m), 64'd0);
    check("rst_out_count", 64'(cnt_m), 64'd0);
    check("rst_out_ovf",   64'(ovf_m), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    check("rst_in_ready", 64'(ir_m), 64'd1);

    // Table-driven vectors.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].r);
      check($sformatf("tbl%0d_in_ready", i), 64'(ir_m), 64'(tbl[i].e_ir));
      check($sformatf("tbl%0d_out_valid", i), 64'(ov_m), 64'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        check($sformatf("tbl%0d_out_sum", i), 64'(sum_m), 64'(tbl[i].e_sum));
        check($sformatf("tbl%0d_out_count", i), 64'(cnt_m), 64'(tbl[i].e_cnt));
      end
    end

    // Backpressure: three stalled cycles with in_valid high, then release.
    drive(1'b1, 24'h10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 24'h55, 1'b0, 1'b0);
      check("bp_in_ready", 64'(ir_m), 64'd0);
      check("bp_out_valid", 64'(ov_m), 64'd1);
      check("bp_out_sum", 64'(sum_m), 64'h10);
    end
    drive(1'b1, 24'h55, 1'b0, 1'b1);
    check("bp_release_in_ready", 64'(ir_m), 64'd1);
    drive(1'b1, 24'h55, 1'b1, 1'b0);
    check("bp_new_frame_sum", 64'(sum_m), 64'h55);
    check("bp_new_frame_count", 64'(cnt_m), 64'd1);
    drive(1'b0, 24'h0, 1'b0, 1'b1);

    // Reset mid-frame discards the partial sum.
    drive(1'b1, 24'h10, 1'b0, 1'b1);
    drive(1'b1, 24'h10, 1'b0, 1'b1);
    do_reset();
    check("midrst_out_valid", 64'(ov_m), 64'd0);
    drive(1'b1, 24'h3, 1'b0, 1'b1);
    check("midrst_no_early_result", 64'(ov_m), 64'd0);
    drive(1'b1, 24'h4, 1'b1, 1'b0);
    check("midrst_out_valid2", 64'(ov_m), 64'd1);
    check("midrst_out_sum", 64'(sum_m), 64'h7);
    check("midrst_out_count", 64'(cnt_m), 64'd2);

    // Reset while holding a result drops it.
    do_reset();
    check("holdrst_out_valid", 64'(ov_m), 64'd0);
    check("holdrst_out_sum", 64'(sum_m), 64'd0);

    // Overflow on the 24-bit instance.
    select(1);
    do_reset();
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
    drive(1'b1, 24'h000002, 1'b1, 1'b0);
    check("ovf_out_sum", 64'(sum_m), SAT ? 64'hFFFFFF : 64'h000001);
    check("ovf_out_ovf", 64'(ovf_m), 64'(SAT));
    drive(1'b0, 24'h0, 1'b0, 1'b1);
    // Saturation is sticky: adding zero after the clamp keeps the maximum.
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
    drive(1'b1, 24'h000001, 1'b0, 1'b0);
    drive(1'b1, 24'h000000, 1'b1, 1'b0);
    check("sticky_out_sum", 64'(sum_m), SAT ? 64'hFFFFFF : 64'h0);
    check("sticky_out_ovf", 64'(ovf_m), 64'(SAT));
    check("sticky_out_count", 64'(cnt_m), 64'd3);
    drive(1'b0, 24'h0, 1'b0, 1'b1);
    // Next frame starts clean.
    drive(1'b1, 24'h000005, 1'b1, 1'b0);
    check("post_ovf_sum", 64'(sum_m), 64'h5);
    check("post_ovf_flag", 64'(ovf_m), 64'd0);

    // LEN=1: back-to-back valid with out_ready high accepts a beat every 2nd cycle.
    select(2);
    do_reset();
    for (int i = 0; i < 8; i++) model_cycle(1'b1, 24'(i + 1), 1'b0, 1'b1);

    // Randomized traffic on every instance against the frame model.
    for (int s = 0; s < 3; s++) begin
      select(s);
      do_reset();
      for (int i = 0; i < 400; i++) begin
        case ($urandom_range(0, 3))
          0: rp = 24'hFFFFFF;
          1: rp = 24'h0;
          default: rp = 24'($urandom());
        endcase
        model_cycle($urandom_range(0, 3) != 0, rp, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 2) != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
